// File: rtl/counter_pkg.sv
// Shared types for the mode counter: counting modes
// and the direction encoding used by the ping-pong FSM.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'd0,
    MODE_DOWN     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_HOLD     = 2'd3
  } ctr_mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/mode_counter.sv
// Up/down/ping-pong counter with clamped load, wrap pulse
// and terminal-count flags.
module mode_counter
  import counter_pkg::*;
#(
  parameter int             N        = 8,
  parameter logic [N-1:0]   MAX_VAL  = '1,
  parameter bit             SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  ctr_mode_t        mode,
  input  logic             load,
  input  logic [N-1:0]     load_val,
  output logic [N-1:0]     count,
  output logic             dir,
  output logic             wrap,
  output logic             at_max,
  output logic             at_zero
);

  logic [N-1:0] count_d;
  logic         dir_d;
  logic         wrap_d;

  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      dir   <= DIR_UP;
      wrap  <= 1'b0;
    end else begin
      count <= count_d;
      dir   <= dir_d;
      wrap  <= wrap_d;
    end
  end

  always_comb begin
    count_d = count;
    dir_d   = dir;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else begin
      // Fixed-direction modes pin dir even when idle
      unique case (1'b1)
        mode == MODE_UP:   dir_d = DIR_UP;
        mode == MODE_DOWN: dir_d = DIR_DOWN;
        default: ;
      endcase
      if (en) begin
        unique case (1'b1)
          mode == MODE_UP: begin
            if (at_max) begin
              wrap_d  = 1'b1;
              count_d = SATURATE ? MAX_VAL : '0;
            end else begin
              count_d = count + 1'b1;
            end
          end
          mode == MODE_DOWN: begin
            if (at_zero) begin
              wrap_d  = 1'b1;
              count_d = SATURATE ? '0 : MAX_VAL;
            end else begin
              count_d = count - 1'b1;
            end
          end
          mode == MODE_PINGPONG: begin
            if (dir == DIR_UP) begin
              if (at_max) begin
                wrap_d  = 1'b1;
                dir_d   = DIR_DOWN;
                count_d = MAX_VAL - 1'b1;
              end else begin
                count_d = count + 1'b1;
              end
            end else begin
              if (at_zero) begin
                wrap_d  = 1'b1;
                dir_d   = DIR_UP;
                count_d = {{(N-1){1'b0}}, 1'b1};
              end else begin
                count_d = count - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
